// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 set-2 byte constants, parser state encoding and the FIFO entry
// layout used by the make-code filter.
package ps2_codes_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] BAT_OK         = 8'hAA;
    localparam logic [7:0] ACK            = 8'hFA;
    localparam logic [7:0] ECHO           = 8'hEE;
    localparam logic [7:0] RESEND         = 8'hFE;
    localparam logic [7:0] ERR0           = 8'h00;
    localparam logic [7:0] ERR1           = 8'hFF;
    localparam logic [7:0] FAKE_SHIFT_A   = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_B   = 8'h59;
    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BREAK,
        EXT_BREAK,
        PAUSE
    } parse_state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_entry_t;

    // Keyboard status replies and error bytes that never start a key sequence.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == ERR0) || (b == BAT_OK) || (b == ECHO) ||
               (b == ACK)  || (b == RESEND) || (b == ERR1);
    endfunction

endpackage

// File: rtl/ps2_make_code_filter_if.sv
// Byte-in / key-out bundle of the make-code filter. master = filter side,
// slave = receiver + consumer side.
interface ps2_make_code_filter_if #(
    parameter int FIFO_DEPTH = 4
) ();

    logic [7:0]                  ps2_received_data;
    logic                        ps2_received_data_strb;
    logic [7:0]                  key_code;
    logic                        key_extended;
    logic                        key_valid;
    logic                        key_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        overflow;

    modport master (
        input  ps2_received_data,
        input  ps2_received_data_strb,
        input  key_ready,
        output key_code,
        output key_extended,
        output key_valid,
        output fifo_level,
        output overflow
    );

    modport slave (
        output ps2_received_data,
        output ps2_received_data_strb,
        output key_ready,
        input  key_code,
        input  key_extended,
        input  key_valid,
        input  fifo_level,
        input  overflow
    );

endinterface

// File: rtl/ps2_code_fifo.sv
// Synchronous FIFO, power-of-two depth. Push on a full FIFO is accepted only
// when a pop happens in the same cycle; pop on an empty FIFO is ignored.
module ps2_code_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    // NOTE: storage is not reset; consumers gate rdata with empty, so stale
    // contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_make_code_filter.sv
// Set-2 scan-code parser with typematic-repeat suppression; emits one FIFO
// entry {ext, code} per key press toward the Morse controller.
module ps2_make_code_filter
    import ps2_codes_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ps2_make_code_filter_if.master bus
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    parse_state_e state_q, state_d;
    logic [2:0]   skip_q, skip_d;
    logic         cand_valid;
    key_entry_t   cand;
    logic         release_seen;
    logic         last_valid_q;
    key_entry_t   last_make_q;
    logic         overflow_q;
    logic         push_req;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [8:0]   fifo_rdata;
    logic [LW-1:0] fifo_level;
    key_entry_t   head;
    logic [7:0]   rx_byte;

    assign rx_byte = bus.ps2_received_data;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        cand_valid   = 1'b0;
        cand         = '0;
        release_seen = 1'b0;
        if (bus.ps2_received_data_strb) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = EXT;
                    end else if (rx_byte == PS2_BREAK) begin
                        state_d = BREAK;
                    end else if (rx_byte == PS2_PAUSE) begin
                        state_d = PAUSE;
                        skip_d  = PAUSE_TAIL_LEN;
                    end else if (!is_status_byte(rx_byte)) begin
                        cand_valid = 1'b1;
                        cand       = '{ext: 1'b0, code: rx_byte};
                    end
                end
                EXT: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_d = EXT_BREAK;
                    end else if (rx_byte == PS2_EXT) begin
                        state_d = EXT;
                    end else if (rx_byte == FAKE_SHIFT_A || rx_byte == FAKE_SHIFT_B) begin
                        state_d = IDLE;
                    end else begin
                        cand_valid = 1'b1;
                        cand       = '{ext: 1'b1, code: rx_byte};
                        state_d    = IDLE;
                    end
                end
                BREAK, EXT_BREAK: begin
                    release_seen = 1'b1;
                    state_d      = IDLE;
                end
                PAUSE: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push_req  = cand_valid & ~(last_valid_q & (cand == last_make_q));
    assign fifo_pop  = ~fifo_empty & bus.key_ready;
    assign fifo_push = push_req & (~fifo_full | fifo_pop);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            skip_q       <= '0;
            last_valid_q <= 1'b0;
            last_make_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            if (release_seen) begin
                last_valid_q <= 1'b0;
            end else if (push_req) begin
                // Updated even when the entry is dropped, so held-key repeats
                // of a lost press do not sneak in later.
                last_valid_q <= 1'b1;
                last_make_q  <= cand;
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ps2_code_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cand),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head             = key_entry_t'(fifo_rdata);
    assign bus.key_code     = fifo_empty ? 8'h00 : head.code;
    assign bus.key_extended = fifo_empty ? 1'b0  : head.ext;
    assign bus.key_valid    = ~fifo_empty;
    assign bus.fifo_level   = fifo_level;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_make_code_filter.sv
// Self-checking bench: directed scenarios plus random byte streams, compared
// each cycle against a queue-based key-press model.
module tb_ps2_make_code_filter;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ps2_make_code_filter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_make_code_filter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: prefix flags plus a queue of pending key presses.
    bit         m_ext;
    bit         m_release;
    int         m_pause_left;
    bit         m_last_valid;
    logic [8:0] m_last;
    logic [8:0] m_q[$];
    bit         m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_release = 0; m_pause_left = 0;
        m_last_valid = 0; m_last = '0; m_ovf = 0;
        m_q.delete();
    endtask

    function automatic bit status_byte(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE ||
               b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic model_step(input logic s, input logic [7:0] b, input logic r);
        bit         pop;
        bit         have;
        logic [8:0] c;
        int         size_before;
        pop = r && (m_q.size() > 0);
        have = 0;
        c = '0;
        size_before = m_q.size();
        if (s) begin
            if (m_pause_left > 0) begin
                m_pause_left--;
            end else if (m_release) begin
                m_release = 0; m_ext = 0; m_last_valid = 0;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else if (b == 8'hF0) begin
                m_release = 1;
            end else if (b == 8'hE1 && !m_ext) begin
                m_pause_left = 7;
            end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
                m_ext = 0;
            end else if (!m_ext && status_byte(b)) begin
                // status reply: ignored
            end else begin
                c = {m_ext, b}; have = 1; m_ext = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (have && !(m_last_valid && m_last == c)) begin
            m_last = c; m_last_valid = 1;
            if (size_before == DEPTH && !pop) m_ovf = 1;
            else m_q.push_back(c);
        end
    endtask

    task automatic compare_outputs();
        bit         nonempty;
        logic [8:0] h;
        nonempty = m_q.size() > 0;
        h = nonempty ? m_q[0] : 9'h000;
        check("key_valid",    32'(bus.key_valid),    32'(nonempty));
        check("key_code",     32'(bus.key_code),     32'(h[7:0]));
        check("key_extended", 32'(bus.key_extended), 32'(h[8]));
        check("fifo_level",   32'(bus.fifo_level),   32'(m_q.size()));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
    endtask

    task automatic step(input logic s, input logic [7:0] b, input logic r);
        bus.ps2_received_data_strb = s;
        bus.ps2_received_data      = b;
        bus.key_ready              = r;
        @(posedge clk);
        model_step(s, b, r);
        #1;
        bus.ps2_received_data_strb = 1'b0;
        bus.key_ready              = 1'b0;
        compare_outputs();
    endtask

    task automatic feed(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1);
    endtask

    // Asynchronous reset pulse, asserted and released away from clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.ps2_received_data_strb = 1'b0;
        bus.key_ready = 1'b0;
        #2;
        model_reset();
        check("rst_valid",    32'(bus.key_valid),    32'd0);
        check("rst_code",     32'(bus.key_code),     32'd0);
        check("rst_extended", 32'(bus.key_extended), 32'd0);
        check("rst_level",    32'(bus.fifo_level),   32'd0);
        check("rst_overflow", 32'(bus.overflow),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] codes [6];
        n_checks = 0;
        n_errors = 0;
        bus.ps2_received_data = 8'h00;
        codes = '{8'h1C, 8'h1D, 8'h24, 8'h75, 8'h29, 8'h15};
        model_reset();
        do_reset();

        // Make then break of the same key.
        feed(8'h1C);
        check("mb_valid_next_cycle", 32'(bus.key_valid), 32'd1);
        feed(8'hF0);
        feed(8'h1C);
        check("mb_level", 32'(bus.fifo_level), 32'd1);
        check("mb_code",  32'(bus.key_code),   32'h1C);
        pop_one();
        check("mb_empty", 32'(bus.key_valid),  32'd0);

        // Extended key with typematic repeats and a release in between.
        foreach (codes[i]) begin end
        feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'h75);
        feed(8'hE0); feed(8'hF0); feed(8'h75); feed(8'hE0); feed(8'h75);
        check("ext_level", 32'(bus.fifo_level),   32'd2);
        check("ext_flag",  32'(bus.key_extended), 32'd1);
        pop_one(); pop_one();

        // Status replies and the Pause sequence leave nothing behind.
        feed(8'hAA); feed(8'hFA);
        feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
        feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77);
        check("pause_empty", 32'(bus.key_valid), 32'd0);
        feed(8'h29);
        check("pause_after", 32'(bus.key_code),   32'h29);
        check("pause_level", 32'(bus.fifo_level), 32'd1);
        pop_one();

        // Full FIFO with a pop in the same cycle as a new make.
        do_reset();
        feed(8'h15); feed(8'h1D); feed(8'h24); feed(8'h2D);
        step(1'b1, 8'h35, 1'b1);
        check("fullpop_level",    32'(bus.fifo_level), 32'd4);
        check("fullpop_overflow", 32'(bus.overflow),   32'd0);
        pop_one(); pop_one(); pop_one();
        check("fullpop_tail", 32'(bus.key_code), 32'h35);
        pop_one();

        // Overflow on a full FIFO with no consumer.
        do_reset();
        feed(8'h15); feed(8'h1D); feed(8'h24); feed(8'h2D); feed(8'h2C);
        check("ovf_flag",  32'(bus.overflow),   32'd1);
        check("ovf_level", 32'(bus.fifo_level), 32'd4);
        check("ovf_head",  32'(bus.key_code),   32'h15);
        pop_one(); pop_one(); pop_one();
        check("ovf_last_head", 32'(bus.key_code), 32'h2D);
        pop_one();
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset in the middle of an extended sequence.
        do_reset();
        feed(8'hE0);
        do_reset();
        feed(8'h1C);
        check("midrst_code", 32'(bus.key_code),     32'h1C);
        check("midrst_ext",  32'(bus.key_extended), 32'd0);
        pop_one();

        // Random byte streams, back-to-back strobes and random consumer.
        for (int n = 0; n < 800; n++) begin
            logic [7:0] b;
            int         r;
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1: b = 8'hE0;
                2, 3: b = 8'hF0;
                4:    b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hAA;
                5:    b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'hFA;
                default: b = codes[$urandom_range(0, 5)];
            endcase
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) == 0);
            if (n == 400) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
